// File: rtl/inst_enc_pkg.sv
// Shared types for the RV32I instruction encoder: op indices, formats, opcode/func7 constants
// and the op-to-encoding lookup used by stage 1.
package inst_enc_pkg;

  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_EBREAK
  } op_e;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS} fmt_e;

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    fmt_e       fmt;
    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
  } dec_t;

  function automatic dec_t op_decode(input logic [5:0] op);
    dec_t d;
    d = '{fmt: FMT_SYS, opc: OPC_SYSTEM, f3: 3'd0, f7: F7_ZERO};
    case (op)
      OP_LUI:   begin d.fmt = FMT_U; d.opc = OPC_LUI;   end
      OP_AUIPC: begin d.fmt = FMT_U; d.opc = OPC_AUIPC; end
      OP_JAL:   begin d.fmt = FMT_J; d.opc = OPC_JAL;   end
      OP_JALR:  begin d.fmt = FMT_I; d.opc = OPC_JALR;  end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
        begin d.fmt = FMT_B; d.opc = OPC_BRANCH; end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
        begin d.fmt = FMT_I; d.opc = OPC_LOAD; end
      OP_SB, OP_SH, OP_SW:
        begin d.fmt = FMT_S; d.opc = OPC_STORE; end
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI:
        begin d.fmt = FMT_I; d.opc = OPC_OPIMM; end
      OP_SLLI, OP_SRLI, OP_SRAI:
        begin d.fmt = FMT_ISH; d.opc = OPC_OPIMM; end
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND:
        begin d.fmt = FMT_R; d.opc = OPC_OP; end
      default: ;
    endcase
    // func3 grouped by value; everything not listed is 000
    case (op)
      OP_BNE, OP_LH, OP_SH, OP_SLLI, OP_SLL:                 d.f3 = 3'd1;
      OP_LW, OP_SW, OP_SLTI, OP_SLT:                         d.f3 = 3'd2;
      OP_SLTIU, OP_SLTU:                                     d.f3 = 3'd3;
      OP_BLT, OP_LBU, OP_XORI, OP_XOR:                       d.f3 = 3'd4;
      OP_BGE, OP_LHU, OP_SRLI, OP_SRAI, OP_SRL, OP_SRA:      d.f3 = 3'd5;
      OP_BLTU, OP_ORI, OP_OR:                                d.f3 = 3'd6;
      OP_BGEU, OP_ANDI, OP_AND:                              d.f3 = 3'd7;
      default:                                               d.f3 = 3'd0;
    endcase
    if (op == OP_SUB || op == OP_SRA || op == OP_SRAI) d.f7 = F7_ALT;
    return d;
  endfunction

  // True when v is the sign extension of its low 'bits' bits
  function automatic logic fits_signed(input logic [31:0] v, input int bits);
    logic [31:0] t;
    t = 32'($signed(v) >>> (bits - 1));
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/inst_enc_pack.sv
// Combinational stage-2 field packer; immediate range check present only when
// INST_ENC_RANGE_CHK_EN is defined.
module inst_enc_pack
  import inst_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [4:0]  opc,
  input  logic [2:0]  f3,
  input  logic [6:0]  f7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic        illegal,
  output logic [31:0] inst,
  output logic        err
);

  logic [6:0] op7;
  logic       bad;

  assign op7 = {opc, 2'b11};

  always_comb begin
    inst = 32'h0;
    case (fmt_e'(fmt))
      FMT_R:   inst = {f7, rs2, rs1, f3, rd, op7};
      FMT_I:   inst = {imm[11:0], rs1, f3, rd, op7};
      FMT_ISH: inst = {f7, imm[4:0], rs1, f3, rd, op7};
      FMT_S:   inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op7};
      FMT_B:   inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op7};
      FMT_U:   inst = {imm[31:12], rd, op7};
      FMT_J:   inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op7};
      default: inst = 32'h0010_0073;
    endcase
    if (illegal) inst = 32'h0;
  end

`ifdef INST_ENC_RANGE_CHK_EN
  always_comb begin
    bad = 1'b0;
    case (fmt_e'(fmt))
      FMT_I, FMT_S: bad = !fits_signed(imm, 12);
      FMT_B:        bad = imm[0] || !fits_signed(imm, 13);
      FMT_J:        bad = imm[0] || !fits_signed(imm, 21);
      FMT_U:        bad = (imm[11:0] != 12'd0);
      FMT_ISH:      bad = (imm[31:5] != 27'd0);
      default:      bad = 1'b0;
    endcase
  end
`else
  assign bad = 1'b0;
`endif

  assign err = illegal | bad;

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder: stage 1 decodes the op index, stage 2
// registers the packed word. Optional immediate range check via INST_ENC_RANGE_CHK_EN.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int INST_NR = 38,
  parameter int OP_W    = 6,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] out_cnt
);

  logic        s1_valid, s2_valid, s1_load, s2_load;
  logic [2:0]  s1_fmt;
  logic [4:0]  s1_opc, s1_rd, s1_rs1, s1_rs2;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [31:0] s1_imm;
  logic        s1_illegal;
  logic [31:0] pk_inst;
  logic        pk_err;
  dec_t        dec;

  // A stage may load when empty or when its contents leave this cycle
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;
  assign dec       = op_decode(6'(in_op));

  inst_enc_pack u_pack (
    .fmt     (s1_fmt),
    .opc     (s1_opc),
    .f3      (s1_f3),
    .f7      (s1_f7),
    .rd      (s1_rd),
    .rs1     (s1_rs1),
    .rs2     (s1_rs2),
    .imm     (s1_imm),
    .illegal (s1_illegal),
    .inst    (pk_inst),
    .err     (pk_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_fmt     <= 3'd0;
      s1_opc     <= 5'd0;
      s1_f3      <= 3'd0;
      s1_f7      <= 7'd0;
      s1_rd      <= 5'd0;
      s1_rs1     <= 5'd0;
      s1_rs2     <= 5'd0;
      s1_imm     <= 32'd0;
      s1_illegal <= 1'b0;
      out_inst   <= 32'd0;
      out_err    <= 1'b0;
      out_cnt    <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_fmt     <= dec.fmt;
          s1_opc     <= dec.opc;
          s1_f3      <= dec.f3;
          s1_f7      <= dec.f7;
          s1_rd      <= in_rd;
          s1_rs1     <= in_rs1;
          s1_rs2     <= in_rs2;
          s1_imm     <= in_imm;
          s1_illegal <= (int'(in_op) >= INST_NR);
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_inst <= pk_inst;
          out_err  <= pk_err;
        end
      end
      if (s2_valid && out_ready) out_cnt <= out_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RV32I instruction encoder, the inverse of the NPC decode lookup: takes an operation index plus register and immediate fields and emits the 32-bit instruction word.
- Used by the self-test and instruction-injection path to build instruction streams into IFU/IMEM without a software assembler.
- Two-stage valid/ready pipeline. Stage 1 resolves the operation into format/opcode/func3/func7; stage 2 packs fields and checks the immediate.

Parameters:
- INST_NR, 38, number of legal operation indices (0..INST_NR-1).
- OP_W, 6, width of the operation index.
- CNT_W, 32, width of the emitted-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request this cycle
- in_op  in  OP_W  operation index, fixed order: LUI=0, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU=9, LB=10, LH, LW, LBU, LHU, SB=15, SH, SW, ADDI=18, SLTI, SLTIU, XORI, ORI, ANDI, SLLI=24, SRLI, SRAI, ADD=27, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND=36, EBREAK=37
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_imm  in  32  byte-offset or value immediate, two's complement
- out_valid  out  1  instruction word valid
- out_ready  in  1  downstream accepts
- out_inst  out  32  encoded instruction
- out_err  out  1  illegal op (or immediate out of range, see Optional Feature)
- out_cnt  out  CNT_W  number of completed output handshakes

Behaviour:
- Reset (rst_n low at a clk edge): both stage valids=0, out_valid=0, out_inst=0, out_err=0, out_cnt=0. Reset overrides every other event, and in-flight entries are discarded.
- Handshake: a transfer occurs when valid&&ready. Each stage loads when it is empty or its successor accepts this cycle.
  - in_ready = !s1_valid || s2_accept.
  - out_valid = s2_valid.
  - out_inst and out_err stay stable while out_valid&&!out_ready.
- Latency is 2 cycles from input handshake to out_valid, at full throughput of 1 instruction/cycle. Order is preserved.
- Stage 1: the op index maps to {format, opcode[6:2], func3, func7}. opcode[1:0]=2'b11. Formats are R, I, I-shift, S, B, U, J, SYS. The stage registers rd, rs1, rs2 and imm alongside.
- Stage 2 packing (unused fields are 0):
  - R: {func7, rs2, rs1, f3, rd, op}.
  - I: {imm[11:0], rs1, f3, rd, op}.
  - I-shift: {func7, imm[4:0], rs1, f3, rd, op}. func7 is 0100000 for SRAI and 0 otherwise.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - SYS (EBREAK): fixed 32'h0010_0073; all fields ignored.
- Illegal op (>= INST_NR): out_inst=32'h0000_0000, out_err=1, counted as a normal output.
- out_cnt increments on each out_valid&&out_ready and wraps modulo 2^CNT_W.
- A simultaneous input and output handshake with both stages full is legal and must not drop or duplicate an entry.

Optional Feature:
- Macro INST_ENC_RANGE_CHK_EN.
- When defined, stage 2 sets out_err=1 if the immediate is not encodable. The word is still emitted with truncated fields. An immediate is not encodable when:
  - I/S: imm is not a sign-extended 12-bit value.
  - B: imm[0]!=0, or imm is not a 13-bit signed value.
  - J: imm[0]!=0, or imm is not a 21-bit signed value.
  - U: imm[11:0]!=0.
  - I-shift: imm[31:5]!=0.
  - R/SYS: never.
- When undefined, fields are silently truncated and out_err reflects only an illegal op.

Decomposition:
- Package inst_enc_pkg holds:
  - the op index enum (order above);
  - the format enum;
  - opcode[6:2] constants (LUI 01101, AUIPC 00101, JAL 11011, JALR 11001, BRANCH 11000, LOAD 00000, STORE 01000, OPIMM 00100, OP 01100, SYSTEM 11100);
  - the func7 constants.
- Sub-module inst_enc_pack is the purely combinational stage-2 packer and range checker. The pipeline and handshake logic stay in inst_encoder.

Test Plan:
- ADDI op=18, rd=1, rs1=0, imm=5 → out_inst=0x00500093, err=0, out_valid exactly 2 cycles after accept.
- BEQ op=4, rs1=1, rs2=2, imm=8 → 0x00208463. JAL op=2, rd=1, imm=2048 → 0x001000EF.
- SRAI op=26, rd=3, rs1=3, imm=4 → 0x4041D193. EBREAK op=37 with random fields → 0x00100073.
- Back-to-back requests with out_ready held low 3 cycles → in_ready drops after 2 accepts, outputs stable, all words arrive in order with no loss, out_cnt=3 after drain.
- Illegal op=40 → out_inst=0, out_err=1. With INST_ENC_RANGE_CHK_EN, ADDI imm=0x800 → err=1 and word 0x80000013 (rd=rs1=0). Without the macro, the same request gives err=0.
- rst_n low for one cycle with both stages full → next cycle out_valid=0, out_cnt=0, in_ready=1, and no stale word appears afterward.
